// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: one BPC-bit full-adder slice is reused WIDTH/BPC times,
// least-significant digit first, with valid/ready handshakes on both sides.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS  = WIDTH / BPC;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  generate
    if (WIDTH < 1 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 1 and divisible by BPC");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic                carry;
  logic [STEP_W-1:0]   step;

  logic [BPC-1:0]      digit;
  logic                carry_next;
  logic                carry_into_top;
  logic [WIDTH-1:0]    res_next;

  // One ripple slice; the carry into its top bit feeds the overflow flag on the last step
  always_comb begin
    logic c;
    c              = carry;
    digit          = '0;
    carry_into_top = carry;
    for (int i = 0; i < BPC; i++) begin
      if (i == BPC - 1) carry_into_top = c;
      digit[i] = op_a[i] ^ op_b[i] ^ c;
      c        = (op_a[i] & op_b[i]) | (c & (op_a[i] ^ op_b[i]));
    end
    carry_next = c;
  end

  // Digits enter from the MSB side so the result is aligned once all steps are done
  generate
    if (STEPS > 1) begin : g_shift
      logic [WIDTH-BPC-1:0] res_shift;

      assign res_next = {digit, res_shift};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          res_shift <= '0;
        end else if (state == S_RUN) begin
          res_shift <= res_next[WIDTH-1:BPC];
        end
      end
    end else begin : g_single
      assign res_next = digit;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      step      <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_a     <= a;
            op_b     <= sub ? ~b : b;
            carry    <= sub ? 1'b1 : cin;
            step     <= '0;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          op_a  <= op_a >> BPC;
          op_b  <= op_b >> BPC;
          carry <= carry_next;
          step  <= step + 1'b1;
          if (step == LAST_STEP) begin
            sum       <= res_next;
            cout      <= carry_next;
            ovf       <= carry_into_top ^ carry_next;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder in three configurations running in lockstep:
// 8-bit/1 bit per cycle, 8-bit/4 bits per cycle and 16-bit/2 bits per cycle.
module tb_serial_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic        sub;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;

  logic        ir8, ov8, co8, vf8;
  logic [7:0]  sum8;
  logic        ir84, ov84, co84, vf84;
  logic [7:0]  sum84;
  logic        ir16, ov16, co16, vf16;
  logic [15:0] sum16;

  int n_vec  = 0;
  int n_miss = 0;
  int lat8, lat84, lat16;

  serial_adder #(.WIDTH(8), .BPC(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin), .sub(sub), .out_valid(ov8), .out_ready(out_ready),
    .sum(sum8), .cout(co8), .ovf(vf8)
  );

  serial_adder #(.WIDTH(8), .BPC(4)) dut84 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir84), .a(a8), .b(b8),
    .cin(cin), .sub(sub), .out_valid(ov84), .out_ready(out_ready),
    .sum(sum84), .cout(co84), .ovf(vf84)
  );

  serial_adder #(.WIDTH(16), .BPC(2)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin), .sub(sub), .out_valid(ov16), .out_ready(out_ready),
    .sum(sum16), .cout(co16), .ovf(vf16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one operation, wait for the accept edge, then count edges until each DUT is valid
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic sb);
    a8 = av[7:0];
    b8 = bv[7:0];
    a16 = av;
    b16 = bv;
    cin = ci;
    sub = sb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat8 = 0;
    lat84 = 0;
    lat16 = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (ov8 && lat8 == 0) lat8 = cyc;
      if (ov84 && lat84 == 0) lat84 = cyc;
      if (ov16 && lat16 == 0) lat16 = cyc;
      if (lat8 != 0 && lat84 != 0 && lat16 != 0) break;
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_vec++;
    if ({ir8, ov8, sum8, co8, vf8, ir84, ov84, sum84, co84, vf84, ir16, ov16, sum16, co16, vf16}
        !== {1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b00}) begin
      n_miss++;
      $display("[TB] FAIL reset_power_on: ready=%b%b%b valid=%b%b%b sum=%h/%h/%h, required ready=111 valid=000 sum=0",
               ir8, ir84, ir16, ov8, ov84, ov16, sum8, sum84, sum16);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_op(16'h005A, 16'h003C, 1'b0, 1'b0);
    n_vec++;
    if ({ov8, ov84, ov16} !== 3'b111) begin
      n_miss++;
      $display("[TB] FAIL reset_pre_op_valid: valid=%b%b%b, required 111", ov8, ov84, ov16);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({ir8, ov8, sum8, co8, vf8} !== {1'b1, 1'b0, 8'h00, 2'b00}) begin
      n_miss++;
      $display("[TB] FAIL reset_async_w8b1: ready=%b valid=%b sum=%h cout=%b ovf=%b, required 1 0 00 0 0",
               ir8, ov8, sum8, co8, vf8);
    end
    n_vec++;
    if ({ir84, ov84, sum84, co84, vf84} !== {1'b1, 1'b0, 8'h00, 2'b00}) begin
      n_miss++;
      $display("[TB] FAIL reset_async_w8b4: ready=%b valid=%b sum=%h cout=%b ovf=%b, required 1 0 00 0 0",
               ir84, ov84, sum84, co84, vf84);
    end
    n_vec++;
    if ({ir16, ov16, sum16, co16, vf16} !== {1'b1, 1'b0, 16'h0000, 2'b00}) begin
      n_miss++;
      $display("[TB] FAIL reset_async_w16b2: ready=%b valid=%b sum=%h cout=%b ovf=%b, required 1 0 0000 0 0",
               ir16, ov16, sum16, co16, vf16);
    end
    #1;
    rst = 1'b0;
  endtask

  // 16-bit operands are the 8-bit ones sign-extended
  task automatic test_add_sub();
    logic [15:0] va [5] = '{16'h005A, 16'hFFFF, 16'hFFFF, 16'h0010, 16'hFF80};
    logic [15:0] vb [5] = '{16'h003C, 16'h0001, 16'h0000, 16'h0020, 16'h0001};
    logic        vc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0]  e8 [5] = '{{8'h96, 2'b01}, {8'h00, 2'b10}, {8'h00, 2'b10},
                            {8'hF0, 2'b00}, {8'h7F, 2'b11}};
    logic [17:0] e16 [5] = '{{16'h0096, 2'b00}, {16'h0000, 2'b10}, {16'h0000, 2'b10},
                             {16'hFFF0, 2'b00}, {16'hFF7F, 2'b10}};
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vc[i], vs[i]);
      n_vec++;
      if ({sum8, co8, vf8} !== e8[i]) begin
        n_miss++;
        $display("[TB] FAIL add_sub%0d_w8b1: sum,cout,ovf=%h,%b,%b required %h,%b,%b",
                 i, sum8, co8, vf8, e8[i][9:2], e8[i][1], e8[i][0]);
      end
      n_vec++;
      if ({sum84, co84, vf84} !== e8[i]) begin
        n_miss++;
        $display("[TB] FAIL add_sub%0d_w8b4: sum,cout,ovf=%h,%b,%b required %h,%b,%b",
                 i, sum84, co84, vf84, e8[i][9:2], e8[i][1], e8[i][0]);
      end
      n_vec++;
      if ({sum16, co16, vf16} !== e16[i]) begin
        n_miss++;
        $display("[TB] FAIL add_sub%0d_w16b2: sum,cout,ovf=%h,%b,%b required %h,%b,%b",
                 i, sum16, co16, vf16, e16[i][17:2], e16[i][1], e16[i][0]);
      end
      n_vec++;
      if (lat8 != 8 || lat84 != 2 || lat16 != 8) begin
        n_miss++;
        $display("[TB] FAIL add_sub%0d_latency: edges=%0d/%0d/%0d required 8/2/8", i, lat8, lat84, lat16);
      end
      release_op();
    end
  endtask

  task automatic test_backpressure();
    do_op(16'h005A, 16'h003C, 1'b0, 1'b0);
    a8 = 8'h01;
    b8 = 8'h02;
    a16 = 16'h0001;
    b16 = 16'h0002;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if ({ov8, ov84, ov16, ir8, ir84, ir16} !== 6'b111000) begin
        n_miss++;
        $display("[TB] FAIL backpressure_hs%0d: valid=%b%b%b ready=%b%b%b required 111 000",
                 i, ov8, ov84, ov16, ir8, ir84, ir16);
      end
      n_vec++;
      if ({sum8, co8, vf8, sum84, co84, vf84, sum16, co16, vf16}
          !== {8'h96, 2'b01, 8'h96, 2'b01, 16'h0096, 2'b00}) begin
        n_miss++;
        $display("[TB] FAIL backpressure_hold%0d: sum=%h/%h/%h cout=%b%b%b ovf=%b%b%b required 96/96/0096 000 110",
                 i, sum8, sum84, sum16, co8, co84, co16, vf8, vf84, vf16);
      end
    end
    release_op();
    n_vec++;
    if ({ov8, ov84, ov16, ir8, ir84, ir16} !== 6'b000111) begin
      n_miss++;
      $display("[TB] FAIL backpressure_release: valid=%b%b%b ready=%b%b%b required 000 111",
               ov8, ov84, ov16, ir8, ir84, ir16);
    end
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0);
    n_vec++;
    if ({sum8, sum84, sum16} !== {8'h03, 8'h03, 16'h0003} || lat8 != 8 || lat84 != 2 || lat16 != 8) begin
      n_miss++;
      $display("[TB] FAIL backpressure_next_op: sum=%h/%h/%h edges=%0d/%0d/%0d required 03/03/0003 8/2/8",
               sum8, sum84, sum16, lat8, lat84, lat16);
    end
    release_op();
  endtask

  task automatic test_reset_mid_op();
    logic seen_bad;
    a8 = 8'h5A;
    b8 = 8'h3C;
    a16 = 16'h005A;
    b16 = 16'h003C;
    cin = 1'b0;
    sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({ir8, ov8, ir84, ov84, ir16, ov16} !== 6'b101010) begin
      n_miss++;
      $display("[TB] FAIL reset_mid_op_hs: ready/valid=%b%b %b%b %b%b required 10 10 10",
               ir8, ov8, ir84, ov84, ir16, ov16);
    end
    n_vec++;
    if ({sum8, co8, vf8, sum84, co84, vf84, sum16, co16, vf16} !== 36'd0) begin
      n_miss++;
      $display("[TB] FAIL reset_mid_op_out: sum=%h/%h/%h cout=%b%b%b ovf=%b%b%b required all zero",
               sum8, sum84, sum16, co8, co84, co16, vf8, vf84, vf16);
    end
    #1;
    rst = 1'b0;
    seen_bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if ({ov8, ov84, ov16} !== 3'b000 || {ir8, ir84, ir16} !== 3'b111) seen_bad = 1'b1;
    end
    n_vec++;
    if (seen_bad !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL reset_mid_op_aborted: output handshake moved after abort (flag=%b), required 0", seen_bad);
    end
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0);
    n_vec++;
    if ({sum8, co8, vf8, sum84, co84, vf84, sum16, co16, vf16}
        !== {8'h03, 2'b00, 8'h03, 2'b00, 16'h0003, 2'b00}) begin
      n_miss++;
      $display("[TB] FAIL reset_mid_op_next: sum=%h/%h/%h cout=%b%b%b ovf=%b%b%b required 03/03/0003 000 000",
               sum8, sum84, sum16, co8, co84, co16, vf8, vf84, vf16);
    end
    release_op();
  endtask

  // Reference: plain wide addition, overflow from operand/result sign bits
  task automatic test_random();
    logic [15:0] ra, rb, bb16;
    logic [7:0]  bb8;
    logic        rc, rs, ci_eff;
    logic [8:0]  f8;
    logic [16:0] f16;
    logic [9:0]  e8;
    logic [17:0] e16;
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      bb8 = rs ? ~rb[7:0] : rb[7:0];
      bb16 = rs ? ~rb : rb;
      ci_eff = rs ? 1'b1 : rc;
      f8 = {1'b0, ra[7:0]} + {1'b0, bb8} + {8'd0, ci_eff};
      f16 = {1'b0, ra} + {1'b0, bb16} + {16'd0, ci_eff};
      e8 = {f8[7:0], f8[8], (ra[7] == bb8[7]) && (f8[7] != ra[7])};
      e16 = {f16[15:0], f16[16], (ra[15] == bb16[15]) && (f16[15] != ra[15])};
      do_op(ra, rb, rc, rs);
      n_vec++;
      if ({sum8, co8, vf8} !== e8) begin
        n_miss++;
        $display("[TB] FAIL random%0d_w8b1: a=%h b=%h cin=%b sub=%b got %h,%b,%b required %h,%b,%b",
                 k, ra[7:0], rb[7:0], rc, rs, sum8, co8, vf8, e8[9:2], e8[1], e8[0]);
      end
      n_vec++;
      if ({sum84, co84, vf84} !== e8) begin
        n_miss++;
        $display("[TB] FAIL random%0d_w8b4: a=%h b=%h cin=%b sub=%b got %h,%b,%b required %h,%b,%b",
                 k, ra[7:0], rb[7:0], rc, rs, sum84, co84, vf84, e8[9:2], e8[1], e8[0]);
      end
      n_vec++;
      if ({sum16, co16, vf16} !== e16) begin
        n_miss++;
        $display("[TB] FAIL random%0d_w16b2: a=%h b=%h cin=%b sub=%b got %h,%b,%b required %h,%b,%b",
                 k, ra, rb, rc, rs, sum16, co16, vf16, e16[17:2], e16[1], e16[0]);
      end
      release_op();
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cin = 1'b0;
    sub = 1'b0;
    a8 = '0;
    b8 = '0;
    a16 = '0;
    b16 = '0;
    test_reset();
    test_add_sub();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
